// File: rtl/lfsr_bank.sv
// lfsr_bank: multi-lane Fibonacci LFSR source with seed-load handshake, warm-up stepping and period-wrap marker
module lfsr_bank #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter logic [WIDTH-1:0] TAPS = 16'hD008,
  parameter logic [WIDTH-1:0] SEED_STRIDE = 16'h0101,
  parameter int WARMUP = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       seed,
  input  logic                   seed_load,
  input  logic                   en,
  output logic                   ready,
  output logic                   valid,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic                   wrap
);
  localparam int CW = WARMUP > 1 ? $clog2(WARMUP + 1) : 1;
  typedef enum logic [1:0] {IDLE, WARM, RUN} state_e;
  state_e state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0] lane_q, lane_d, stepped, seeded;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic wrap_q, wrap_d, load, adv, enter_run;
  function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS) ^ (s == '0)};
  endfunction
  genvar i;
  for (i = 0; i < LANES; i++) begin : g_lane
    localparam logic [WIDTH-1:0] OFF = WIDTH'(i) * SEED_STRIDE;
    assign stepped[i] = step_f(lane_q[i]);
    assign seeded[i]  = ((seed ^ OFF) == '0) ? WIDTH'(1) : seed ^ OFF;
  end
  assign load = seed_load && state_q != WARM;
  assign adv  = state_q == WARM || (state_q == RUN && en);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      cnt_q   <= '0;
      ref_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      wrap_q  <= wrap_d;
    end
  end
  always_comb begin
    state_d = load ? (WARMUP == 0 ? RUN : WARM) :
              (state_q == WARM && cnt_q == CW'(1)) ? RUN : state_q;
  end
  // reference is taken from the lane 0 value that will be visible on RUN entry or reload
  assign enter_run = state_d == RUN && (state_q != RUN || load);
  always_comb begin
    lane_d = load ? seeded : adv ? stepped : lane_q;
    cnt_d  = load ? CW'(WARMUP) : state_q == WARM ? cnt_q - CW'(1) : cnt_q;
    ref_d  = enter_run ? lane_d[0] : ref_q;
    wrap_d = state_q == RUN && !load && en && stepped[0] == ref_q;
  end
  always_comb begin
    ready    = state_q != WARM;
    valid    = state_q == RUN;
    data_out = lane_q;
    wrap     = wrap_q;
  end
endmodule

// File: tb/tb_lfsr_bank.sv
// tb_lfsr_bank: directed and random checks of three lfsr_bank configurations against a behavioural model
module tb_lfsr_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] seed_in [3];
  logic [2:0] ld = '0, en = '0, rdy, vld, wrp;
  logic [63:0] dout0, dout1;
  logic [3:0] dout2;
  int n_chk = 0, n_fail = 0;
  int W [3] = '{16, 16, 4};
  int L [3] = '{4, 4, 1};
  int T [3] = '{'hD008, 'hD008, 'hC};
  int STR [3] = '{'h0101, 'h0101, 'h1};
  int WU [3] = '{0, 8, 0};
  int m_lane [3][4];
  int m_mode [3];
  int m_cnt [3];
  int m_ref [3];
  int m_wrap [3];
  logic [3:0] seq4 [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  always #5 clk = ~clk;

  lfsr_bank #(.WIDTH(16), .LANES(4), .TAPS(16'hD008), .SEED_STRIDE(16'h0101), .WARMUP(0)) u0 (
    .clk(clk), .reset(reset), .seed(seed_in[0]), .seed_load(ld[0]), .en(en[0]),
    .ready(rdy[0]), .valid(vld[0]), .data_out(dout0), .wrap(wrp[0]));
  lfsr_bank #(.WIDTH(16), .LANES(4), .TAPS(16'hD008), .SEED_STRIDE(16'h0101), .WARMUP(8)) u1 (
    .clk(clk), .reset(reset), .seed(seed_in[1]), .seed_load(ld[1]), .en(en[1]),
    .ready(rdy[1]), .valid(vld[1]), .data_out(dout1), .wrap(wrp[1]));
  lfsr_bank #(.WIDTH(4), .LANES(1), .TAPS(4'hC), .SEED_STRIDE(4'h1), .WARMUP(0)) u2 (
    .clk(clk), .reset(reset), .seed(seed_in[2][3:0]), .seed_load(ld[2]), .en(en[2]),
    .ready(rdy[2]), .valid(vld[2]), .data_out(dout2), .wrap(wrp[2]));

  function automatic int mstep(int s, int w, int t);
    int p = (s == 0) ? 1 : 0;
    for (int b = 0; b < w; b++) p ^= (s >> b) & (t >> b) & 1;
    return ((s << 1) & ((1 << w) - 1)) | p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) m_lane[k][i] = 0;
      m_mode[k] = 0; m_cnt[k] = 0; m_ref[k] = 0; m_wrap[k] = 0;
    end
  endtask

  // mode: 0 idle, 1 warming up, 2 running
  task automatic model_adv(int k);
    int mask = (1 << W[k]) - 1;
    int d;
    m_wrap[k] = 0;
    if (ld[k] && m_mode[k] != 1) begin
      for (int i = 0; i < L[k]; i++) begin
        d = (int'(seed_in[k]) & mask) ^ ((i * STR[k]) % (1 << W[k]));
        m_lane[k][i] = (d == 0) ? 1 : d;
      end
      m_cnt[k] = WU[k];
      m_mode[k] = (WU[k] == 0) ? 2 : 1;
      if (m_mode[k] == 2) m_ref[k] = m_lane[k][0];
    end else if (m_mode[k] == 1) begin
      for (int i = 0; i < L[k]; i++) m_lane[k][i] = mstep(m_lane[k][i], W[k], T[k]);
      m_cnt[k]--;
      if (m_cnt[k] == 0) begin
        m_mode[k] = 2;
        m_ref[k] = m_lane[k][0];
      end
    end else if (m_mode[k] == 2 && en[k]) begin
      for (int i = 0; i < L[k]; i++) m_lane[k][i] = mstep(m_lane[k][i], W[k], T[k]);
      if (m_lane[k][0] == m_ref[k]) m_wrap[k] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_all();
    logic [63:0] e, o;
    for (int k = 0; k < 3; k++) begin
      e = '0;
      for (int i = 0; i < L[k]; i++) e |= 64'(m_lane[k][i]) << (i * W[k]);
      o = (k == 0) ? dout0 : (k == 1) ? dout1 : {60'b0, dout2};
      chk($sformatf("data%0d", k), o, e);
      chk($sformatf("ready%0d", k), 64'(rdy[k]), 64'(m_mode[k] != 1));
      chk($sformatf("valid%0d", k), 64'(vld[k]), 64'(m_mode[k] == 2));
      chk($sformatf("wrap%0d", k), 64'(wrp[k]), 64'(m_wrap[k]));
    end
  endtask

  task automatic cyc();
    for (int k = 0; k < 3; k++) model_adv(k);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int c;
    logic zero_lane;
    for (int k = 0; k < 3; k++) seed_in[k] = '0;
    do_reset();
    chk("rst_data0", dout0, 64'h0);
    chk("rst_ready0", 64'(rdy[0]), 64'h1);
    // 1: base seed fan-out across lanes
    seed_in[0] = 16'h0001; ld[0] = 1'b1;
    cyc();
    ld[0] = 1'b0;
    chk("t1_l0", 64'(dout0[15:0]), 64'h0001);
    chk("t1_l1", 64'(dout0[31:16]), 64'h0100);
    chk("t1_l2", 64'(dout0[47:32]), 64'h0203);
    chk("t1_l3", 64'(dout0[63:48]), 64'h0302);
    chk("t1_valid", 64'(vld[0]), 64'h1);
    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    chk("t1_step", 64'(dout0[15:0]), 64'h0002);
    // 2: zero seed substitution and no lock-up
    seed_in[0] = 16'h0000; ld[0] = 1'b1;
    cyc();
    ld[0] = 1'b0;
    chk("t2_l0", 64'(dout0[15:0]), 64'h0001);
    chk("t2_l1", 64'(dout0[31:16]), 64'h0101);
    for (int j = 0; j < 40; j++) begin
      en[0] = 1'($urandom_range(1));
      cyc();
      zero_lane = 1'b0;
      for (int i = 0; i < 4; i++) if (dout0[i*16 +: 16] == 16'h0) zero_lane = 1'b1;
      chk("t2_nonzero", 64'(zero_lane), 64'h0);
    end
    en[0] = 1'b0;
    // 3: warm-up window ignores a second load
    seed_in[1] = 16'hACE1; ld[1] = 1'b1;
    cyc();
    seed_in[1] = 16'h5555;
    for (int j = 1; j <= 8; j++) begin
      chk("t3_ready", 64'(rdy[1]), 64'h0);
      chk("t3_valid", 64'(vld[1]), 64'h0);
      ld[1] = (j == 3);
      cyc();
    end
    ld[1] = 1'b0;
    chk("t3_valid_up", 64'(vld[1]), 64'h1);
    // 4: 4-bit maximal sequence and period wrap
    seed_in[2] = 16'h0001; ld[2] = 1'b1; en[2] = 1'b1;
    cyc();
    ld[2] = 1'b0;
    chk("t4_seed", 64'(dout2), 64'h1);
    for (int j = 1; j <= 30; j++) begin
      cyc();
      chk("t4_seq", 64'(dout2), 64'(seq4[j % 15]));
      chk("t4_wrap", 64'(wrp[2]), 64'(j % 15 == 0));
    end
    c = 0;
    for (int j = 0; j < 200 && c < 15; j++) begin
      en[2] = 1'($urandom_range(1));
      cyc();
      if (en[2]) c++;
      chk("t4_gap_wrap", 64'(wrp[2]), 64'(en[2] && c == 15));
    end
    chk("t4_gap_done", 64'(c), 64'd15);
    en[2] = 1'b0;
    // 5: reload priority over en, then reset mid warm-up
    en[1] = 1'b1;
    repeat (3) cyc();
    seed_in[1] = 16'h1234; ld[1] = 1'b1;
    cyc();
    ld[1] = 1'b0;
    chk("t5_valid", 64'(vld[1]), 64'h0);
    chk("t5_reload", 64'(dout1[15:0]), 64'h1234);
    repeat (3) cyc();
    do_reset();
    chk("t5_rst_data", dout1, 64'h0);
    chk("t5_rst_ready", 64'(rdy[1]), 64'h1);
    chk("t5_rst_valid", 64'(vld[1]), 64'h0);
    en = '0;
    // random traffic on all three banks
    for (int j = 0; j < 400; j++) begin
      for (int k = 0; k < 3; k++) begin
        seed_in[k] = 16'($urandom);
        ld[k] = ($urandom_range(15) == 0);
        en[k] = ($urandom_range(3) != 0);
      end
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
